cpu_control_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 35 +++
 rtl/cpu_control_unit_if.sv | 28 ++
 rtl/cpu_alu.sv | 39 +++
 rtl/cpu_control_unit.sv | 93 +++++++++
 tb/tb_cpu_control_unit.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit multi-cycle CPU: opcodes, FSM states,
// instruction field layout and datapath defaults.
package cpu_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PC_WIDTH_DEF   = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_LI  = 2'b10,
    OP_JMP = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_e;

  // ir[7:6] op, ir[5:4] rs, ir[3:2] rt, ir[1:0] rd
  typedef struct packed {
    opcode_e    op;
    logic [1:0] rs;
    logic [1:0] rt;
    logic [1:0] rd;
  } instr_t;

  // LI immediate is ir[5:2]; JMP offset is ir[5:0]
  localparam int IMM_LO = 2;
  localparam int IMM_W  = 4;
  localparam int OFF_W  = 6;

endpackage

// File: rtl/cpu_control_unit_if.sv
// Fetch and register-file bus between the control unit (master) and the
// instruction memory / register file (slave).
interface cpu_control_unit_if #(
  parameter int PC_WIDTH   = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  instr_req;
  logic [PC_WIDTH-1:0]   instr_addr;
  logic                  instr_valid;
  logic [7:0]            instr_data;
  logic [1:0]            readReg1;
  logic [1:0]            readReg2;
  logic [1:0]            writeReg;
  logic                  sigRegWrite;
  logic [DATA_WIDTH-1:0] writeData;
  logic [DATA_WIDTH-1:0] readData1;
  logic [DATA_WIDTH-1:0] readData2;

  modport master (
    output instr_req, instr_addr, readReg1, readReg2, writeReg, sigRegWrite, writeData,
    input  instr_valid, instr_data, readData1, readData2
  );

  modport slave (
    input  instr_req, instr_addr, readReg1, readReg2, writeReg, sigRegWrite, writeData,
    output instr_valid, instr_data, readData1, readData2
  );
endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU: ADD/SUB with carry/borrow, LI sign-extends a 4-bit immediate.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  opcode_e               op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [IMM_W-1:0]      imm_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  carry_o,
  output logic                  zero_o
);
  logic [DATA_WIDTH:0] sum, diff;

  // Top bit of the widened difference is the unsigned borrow (a < b)
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    unique case (op_i)
      OP_ADD: begin
        result_o = sum[DATA_WIDTH-1:0];
        carry_o  = sum[DATA_WIDTH];
      end
      OP_SUB: begin
        result_o = diff[DATA_WIDTH-1:0];
        carry_o  = diff[DATA_WIDTH];
      end
      OP_LI:   result_o = {{(DATA_WIDTH-IMM_W){imm_i[IMM_W-1]}}, imm_i};
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);
endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute/writeback controller; owns pc, ir, result
// and the carry/zero flags.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH   = PC_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  cpu_control_unit_if.master     bus,
  output logic                   flag_c,
  output logic                   flag_z,
  output logic [1:0]             state_dbg
);
  state_e                state_q;
  instr_t                ir_q;
  logic [PC_WIDTH-1:0]   pc_q, jmp_pc_d;
  logic [DATA_WIDTH-1:0] result_q, alu_res;
  logic                  c_q, z_q, req_q, wr_q;
  logic                  alu_c, alu_z;

  cpu_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op_i     (ir_q.op),
    .a_i      (bus.readData1),
    .b_i      (bus.readData2),
    .imm_i    ({ir_q.rs, ir_q.rt}),
    .result_o (alu_res),
    .carry_o  (alu_c),
    .zero_o   (alu_z)
  );

  // Offset is relative to the JMP's own address and wraps mod 2^PC_WIDTH
  assign jmp_pc_d = pc_q + {{(PC_WIDTH-OFF_W){ir_q.rs[1]}}, ir_q.rs, ir_q.rt, ir_q.rd};

  // req_q stays low for the first cycle after reset release, then tracks S_FETCH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (req_q && bus.instr_valid) begin
            ir_q    <= instr_t'(bus.instr_data);
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end else begin
            req_q   <= 1'b1;
          end
        end
        S_DECODE: state_q <= S_EXEC;
        S_EXEC: begin
          if (ir_q.op == OP_JMP) begin
            pc_q    <= jmp_pc_d;
            req_q   <= 1'b1;
            state_q <= S_FETCH;
          end else begin
            result_q <= alu_res;
            z_q      <= alu_z;
            if (ir_q.op != OP_LI) c_q <= alu_c;
            wr_q     <= 1'b1;
            state_q  <= S_WB;
          end
        end
        S_WB: begin
          wr_q    <= 1'b0;
          pc_q    <= pc_q + 1'b1;
          req_q   <= 1'b1;
          state_q <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign bus.instr_req   = req_q;
  assign bus.instr_addr  = pc_q;
  assign bus.readReg1    = ir_q.rs;
  assign bus.readReg2    = ir_q.rt;
  assign bus.writeReg    = ir_q.rd;
  assign bus.sigRegWrite = wr_q;
  assign bus.writeData   = result_q;
  assign flag_c          = c_q;
  assign flag_z          = z_q;
  assign state_dbg       = state_q;
endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit with a 4x8 register-file model.
module tb_cpu_control_unit;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       flag_c, flag_z;
  logic [1:0] state_dbg;
  logic [7:0] rf [4];
  logic       load_en = 1'b0;
  int         tests = 0;
  int         fails = 0;

  cpu_control_unit_if #(.PC_WIDTH(8), .DATA_WIDTH(8)) bus ();

  cpu_control_unit #(.PC_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  assign bus.readData1 = rf[bus.readReg1];
  assign bus.readData2 = rf[bus.readReg2];

  always @(posedge clk) begin
    if (load_en) begin
      rf[0] <= 8'h00; rf[1] <= 8'hF0; rf[2] <= 8'h20; rf[3] <= 8'h00;
    end else if (bus.sigRegWrite) begin
      rf[bus.writeReg] <= bus.writeData;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for instr_req, checks the address, and leaves the DUT in S_DECODE
  task automatic fetch(input logic [7:0] d, input logic [7:0] addr);
    int n = 0;
    while (bus.instr_req !== 1'b1 && n < 16) begin tick(); n++; end
    chk("fetch_req", bus.instr_req, 1);
    chk("fetch_addr", bus.instr_addr, addr);
    bus.instr_valid = 1'b1;
    bus.instr_data  = d;
    tick();
    bus.instr_valid = 1'b0;
    bus.instr_data  = 8'h00;
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_data  = 8'h00;
    load_en = 1'b1;
    tick(); tick();
    load_en = 1'b0;
    chk("rst_req",   bus.instr_req, 0);
    chk("rst_wr",    bus.sigRegWrite, 0);
    chk("rst_state", state_dbg, 0);
    chk("rst_addr",  bus.instr_addr, 0);
    chk("rst_c",     flag_c, 0);
    chk("rst_z",     flag_z, 0);
    reset_n = 1'b1;

    repeat (5) begin
      tick();
      chk("idle_req",  bus.instr_req, 1);
      chk("idle_addr", bus.instr_addr, 0);
      chk("idle_wr",   bus.sigRegWrite, 0);
    end

    // LI r1,+5
    fetch(8'h95, 8'h00);
    chk("li_dec_state", state_dbg, 1);
    chk("li_dec_req", bus.instr_req, 0);
    tick();
    chk("li_exec_state", state_dbg, 2);
    chk("li_exec_wr", bus.sigRegWrite, 0);
    tick();
    chk("li_wr",    bus.sigRegWrite, 1);
    chk("li_wreg",  bus.writeReg, 1);
    chk("li_wdata", bus.writeData, 8'h05);
    chk("li_z",     flag_z, 0);
    tick();
    chk("li_next_addr", bus.instr_addr, 1);
    chk("li_wr_off", bus.sigRegWrite, 0);
    chk("li_rf1", rf[1], 8'h05);

    load_en = 1'b1;
    tick();
    load_en = 1'b0;

    // ADD r3,r1,r2 : F0+20 = 110
    fetch(8'h1B, 8'h01);
    chk("add_rr1", bus.readReg1, 1);
    chk("add_rr2", bus.readReg2, 2);
    tick(); tick();
    chk("add_wr",    bus.sigRegWrite, 1);
    chk("add_wreg",  bus.writeReg, 3);
    chk("add_wdata", bus.writeData, 8'h10);
    chk("add_c",     flag_c, 1);
    chk("add_z",     flag_z, 0);
    tick();
    chk("add_rf3", rf[3], 8'h10);

    // SUB r0,r2,r2
    fetch(8'h68, 8'h02);
    tick(); tick();
    chk("sub_wr",    bus.sigRegWrite, 1);
    chk("sub_wreg",  bus.writeReg, 0);
    chk("sub_wdata", bus.writeData, 8'h00);
    chk("sub_z",     flag_z, 1);
    chk("sub_c",     flag_c, 0);
    tick();

    // JMP -4 at pc 3 -> FF, no write, flags kept
    fetch(8'hFC, 8'h03);
    tick();
    chk("jmp_exec_wr", bus.sigRegWrite, 0);
    tick();
    chk("jmp_addr", bus.instr_addr, 8'hFF);
    chk("jmp_req",  bus.instr_req, 1);
    chk("jmp_wr",   bus.sigRegWrite, 0);
    chk("jmp_c",    flag_c, 0);
    chk("jmp_z",    flag_z, 1);

    // LI r2,-1 at FF -> pc wraps to 00
    fetch(8'hBE, 8'hFF);
    tick(); tick();
    chk("lim_wreg",  bus.writeReg, 2);
    chk("lim_wdata", bus.writeData, 8'hFF);
    chk("lim_z",     flag_z, 0);
    chk("lim_c",     flag_c, 0);
    tick();
    chk("wrap_addr", bus.instr_addr, 8'h00);
    chk("lim_rf2",   rf[2], 8'hFF);

    // ADD r1,r1,r1 with junk instr_valid during decode/exec
    fetch(8'h15, 8'h00);
    bus.instr_valid = 1'b1;
    bus.instr_data  = 8'hC0;
    chk("junk_req", bus.instr_req, 0);
    tick(); tick();
    bus.instr_valid = 1'b0;
    chk("junk_wreg",  bus.writeReg, 1);
    chk("junk_wdata", bus.writeData, 8'hE0);
    chk("junk_c",     flag_c, 1);
    tick();
    chk("junk_rf1",  rf[1], 8'hE0);
    chk("junk_addr", bus.instr_addr, 8'h01);

    // JMP +0 loops on itself
    fetch(8'hC0, 8'h01);
    tick(); tick();
    chk("jmp0_addr", bus.instr_addr, 8'h01);
    chk("jmp0_c",    flag_c, 1);
    chk("jmp0_z",    flag_z, 0);

    // ADD r3,r1,r2 aborted by reset in S_WB
    fetch(8'h1B, 8'h01);
    tick(); tick();
    chk("rwb_wr", bus.sigRegWrite, 1);
    reset_n = 1'b0;
    #1;
    chk("rwb_wr_drop", bus.sigRegWrite, 0);
    chk("rwb_state",   state_dbg, 0);
    tick();
    chk("rwb_rf3", rf[3], 8'h10);
    chk("rwb_c",   flag_c, 0);
    chk("rwb_z",   flag_z, 0);
    reset_n = 1'b1;
    tick();
    chk("rwb_addr", bus.instr_addr, 0);
    chk("rwb_req",  bus.instr_req, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
